// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback arbiter slice.
package regfile_pkg;

  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned WORD_W = 32;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FORCE
  } arb_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-writeback scoreboard for long-latency destinations plus rs/rt hazard lookup.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     setValid,
  input  reg_idx_t setReg,
  input  logic     clrValid,
  input  reg_idx_t clrReg,
  input  logic     wbValid,
  input  reg_idx_t wbReg,
  input  reg_idx_t rs,
  input  reg_idx_t rt,
  output logic     rsBusy,
  output logic     rtBusy
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pendingNext;

  // Clear first so a same-cycle issue to the completing register keeps it pending.
  always_comb begin
    pendingNext = pending;
    if (clrValid) begin
      pendingNext[clrReg] = 1'b0;
    end
    if (setValid && (setReg != REG_ZERO)) begin
      pendingNext[setReg] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pendingNext;
    end
  end

  // The write sitting in the output stage is not yet readable from the file.
  assign rsBusy = (rs != REG_ZERO) && (pending[rs] || (wbValid && (wbReg == rs)));
  assign rtBusy = (rt != REG_ZERO) && (pending[rt] || (wbValid && (wbReg == rt)));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline (A) and long-latency (B) writeback.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  input  reg_idx_t          a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  reg_idx_t          b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              issue_valid,
  input  reg_idx_t          issue_reg,
  input  reg_idx_t          rs,
  input  reg_idx_t          rt,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              stall_pipe,
  output logic              regWrite,
  output reg_idx_t          writeReg,
  output logic [DATA_W-1:0] writeData
);

  localparam int unsigned CNT_W = 4;

  arb_state_e       state;
  arb_state_e       stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W-1:0] waitCntNext;
  logic             stallNext;
  logic             aEff;
  logic             bFire;

  assign aEff    = a_valid && (a_reg != REG_ZERO);
  assign b_ready = !aEff && !reset;
  assign bFire   = b_valid && b_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      waitCnt    <= '0;
      stall_pipe <= 1'b0;
    end else begin
      state      <= stateNext;
      waitCnt    <= waitCntNext;
      stall_pipe <= stallNext;
    end
  end

  // Starvation tracking: count consecutive refusals of a held B request.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    stallNext   = (state == FORCE);
    case (state)
      IDLE: begin
        if (b_valid && !b_ready) begin
          waitCntNext = CNT_W'(1);
          stateNext   = (CNT_W'(1) >= CNT_W'(MAX_WAIT)) ? FORCE : WAIT;
        end
      end
      WAIT: begin
        if (!b_valid || bFire) begin
          stateNext   = IDLE;
          waitCntNext = '0;
        end else begin
          waitCntNext = waitCnt + CNT_W'(1);
          if (waitCntNext >= CNT_W'(MAX_WAIT)) begin
            stateNext = FORCE;
          end
        end
      end
      FORCE: begin
        if (!b_valid || bFire) begin
          stateNext   = IDLE;
          waitCntNext = '0;
        end
      end
      default: begin
        stateNext   = IDLE;
        waitCntNext = '0;
      end
    endcase
  end

  // Single output stage towards the register-file write port; A always wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      regWrite  <= 1'b0;
      writeReg  <= REG_ZERO;
      writeData <= '0;
    end else if (aEff) begin
      regWrite  <= 1'b1;
      writeReg  <= a_reg;
      writeData <= a_data;
    end else if (bFire) begin
      regWrite  <= (b_reg != REG_ZERO);
      writeReg  <= b_reg;
      writeData <= b_data;
    end else begin
      regWrite  <= 1'b0;
    end
  end

  regfile_scoreboard uScoreboard (
    .clock    (clock),
    .reset    (reset),
    .setValid (issue_valid),
    .setReg   (issue_reg),
    .clrValid (bFire),
    .clrReg   (b_reg),
    .wbValid  (regWrite),
    .wbReg    (writeReg),
    .rs       (rs),
    .rt       (rt),
    .rsBusy   (rs_busy),
    .rtBusy   (rt_busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_regfile_wb_arbiter;

  localparam int unsigned MAX_WAIT = 4;

  logic        clock;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        rs_busy;
  logic        rt_busy;
  logic        stall_pipe;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          mPend[32];
  bit          mWe;
  logic [4:0]  mReg;
  logic [31:0] mData;
  bit          mStall;
  bit          mForce;
  int          mRefusals;
  bit          mGrantB;

  regfile_wb_arbiter #(.DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clock       (clock),
    .reset       (reset),
    .a_valid     (a_valid),
    .a_reg       (a_reg),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_reg       (b_reg),
    .b_data      (b_data),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .rs          (rs),
    .rt          (rt),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy),
    .stall_pipe  (stall_pipe),
    .regWrite    (regWrite),
    .writeReg    (writeReg),
    .writeData   (writeData)
  );

  initial clock = 1'b0;
  always #50 clock = ~clock;

  function automatic bit exp_busy(input logic [4:0] idx);
    return (idx != 5'd0) && (mPend[idx] || (mWe && (mReg == idx)));
  endfunction

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_update();
    bit aE;
    bit gB;
    if (reset) begin
      for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
      mWe = 1'b0; mReg = '0; mData = '0;
      mStall = 1'b0; mForce = 1'b0; mRefusals = 0; mGrantB = 1'b0;
      return;
    end
    aE = a_valid && (a_reg != 5'd0);
    gB = b_valid && !aE;
    mGrantB = gB;
    if (aE) begin
      mWe = 1'b1; mReg = a_reg; mData = a_data;
    end else if (gB) begin
      mWe = (b_reg != 5'd0); mReg = b_reg; mData = b_data;
    end else begin
      mWe = 1'b0;
    end
    if (gB) mPend[b_reg] = 1'b0;
    if (issue_valid && (issue_reg != 5'd0)) mPend[issue_reg] = 1'b1;
    mStall = mForce;
    if (mForce) begin
      if (gB || !b_valid) begin
        mForce = 1'b0; mRefusals = 0;
      end
    end else if (b_valid && !gB) begin
      mRefusals++;
      if (mRefusals >= int'(MAX_WAIT)) mForce = 1'b1;
    end else begin
      mRefusals = 0;
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_reg = 0; a_data = 0;
    b_valid = 0; b_reg = 0; b_data = 0;
    issue_valid = 0; issue_reg = 0; rs = 0; rt = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; b_valid = 1; b_reg = 5'd7;
    #1;
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL reset_b_ready got=%b exp=0", b_ready); end
    tick(); tick();
    total++; if (regWrite !== 1'b0) begin bad++; $display("FAIL reset_regWrite got=%b exp=0", regWrite); end
    total++; if (stall_pipe !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_pipe); end
    reset = 0; b_valid = 0;
    tick();
  endtask

  task automatic test_reset_mid_fsm();
    int busyCnt;
    issue_valid = 1; issue_reg = 5'd3;
    tick();
    issue_valid = 0;
    a_valid = 1; a_reg = 5'd11; a_data = 32'h1111_0000;
    b_valid = 1; b_reg = 5'd3;  b_data = 32'h33;
    for (int k = 0; k < int'(MAX_WAIT) + 1; k++) tick();
    total++; if (stall_pipe !== 1'b1) begin bad++; $display("FAIL midrst_stall_before got=%b exp=1", stall_pipe); end
    rs = 5'd3;
    a_valid = 0; reset = 1;
    #1;
    total++; if (rs_busy !== 1'b1) begin bad++; $display("FAIL midrst_pending3 got=%b exp=1", rs_busy); end
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL midrst_b_ready got=%b exp=0", b_ready); end
    tick();
    reset = 0; b_valid = 0;
    #1;
    total++; if (stall_pipe !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%b exp=0", stall_pipe); end
    total++; if (regWrite !== 1'b0) begin bad++; $display("FAIL midrst_regWrite got=%b exp=0", regWrite); end
    busyCnt = 0;
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i);
      #1;
      if (rs_busy) busyCnt++;
    end
    total++; if (busyCnt !== 0) begin bad++; $display("FAIL midrst_pending_cleared got=%0d exp=0", busyCnt); end
    rs = 0;
    tick();
  endtask

  task automatic test_a_only();
    a_valid = 1; a_reg = 5'd8; a_data = 32'hDEAD_BEEF;
    tick();
    total++; if (regWrite !== 1'b1) begin bad++; $display("FAIL a_only_we got=%b exp=1", regWrite); end
    total++; if (writeReg !== 5'd8) begin bad++; $display("FAIL a_only_reg got=%0d exp=8", writeReg); end
    total++; if (writeData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL a_only_data got=%h exp=deadbeef", writeData); end
    a_reg = 5'd0; a_data = 32'h1234_5678;
    tick();
    total++; if (regWrite !== 1'b0) begin bad++; $display("FAIL a_zero_we got=%b exp=0", regWrite); end
    a_valid = 0;
    tick();
  endtask

  task automatic test_collision();
    a_valid = 1; a_reg = 5'd9;  a_data = 32'h99;
    b_valid = 1; b_reg = 5'd10; b_data = 32'h5;
    #1;
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL coll_b_ready got=%b exp=0", b_ready); end
    tick();
    total++; if (regWrite !== 1'b1 || writeReg !== 5'd9 || writeData !== 32'h99) begin
      bad++; $display("FAIL coll_a_first got=%b/%0d/%h exp=1/9/99", regWrite, writeReg, writeData); end
    a_valid = 0;
    #1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL coll_b_grant got=%b exp=1", b_ready); end
    tick();
    b_valid = 0;
    total++; if (regWrite !== 1'b1 || writeReg !== 5'd10 || writeData !== 32'h5) begin
      bad++; $display("FAIL coll_b_write got=%b/%0d/%h exp=1/10/5", regWrite, writeReg, writeData); end
    tick();
  endtask

  task automatic test_starvation();
    int n;
    a_valid = 1; a_reg = 5'd11; a_data = 32'hA11;
    b_valid = 1; b_reg = 5'd15; b_data = 32'hB15;
    n = 0;
    while (stall_pipe !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++; if (n !== int'(MAX_WAIT) + 1) begin bad++; $display("FAIL starve_cycles got=%0d exp=%0d", n, MAX_WAIT + 1); end
    a_valid = 0;
    #1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL starve_grant got=%b exp=1", b_ready); end
    tick();
    b_valid = 0;
    total++; if (stall_pipe !== 1'b1) begin bad++; $display("FAIL starve_stall_hold got=%b exp=1", stall_pipe); end
    total++; if (regWrite !== 1'b1 || writeReg !== 5'd15 || writeData !== 32'hB15) begin
      bad++; $display("FAIL starve_b_write got=%b/%0d/%h exp=1/15/b15", regWrite, writeReg, writeData); end
    tick();
    total++; if (stall_pipe !== 1'b0) begin bad++; $display("FAIL starve_stall_drop got=%b exp=0", stall_pipe); end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1; issue_reg = 5'd12;
    tick();
    issue_valid = 0; rs = 5'd12;
    #1;
    total++; if (rs_busy !== 1'b1) begin bad++; $display("FAIL sb_issue_busy got=%b exp=1", rs_busy); end
    b_valid = 1; b_reg = 5'd12; b_data = 32'hC;
    tick();
    b_valid = 0;
    #1;
    total++; if (rs_busy !== 1'b1) begin bad++; $display("FAIL sb_inflight_busy got=%b exp=1", rs_busy); end
    tick();
    total++; if (rs_busy !== 1'b0) begin bad++; $display("FAIL sb_done_busy got=%b exp=0", rs_busy); end
    issue_valid = 1; issue_reg = 5'd13;
    b_valid = 1; b_reg = 5'd13; b_data = 32'hD;
    tick();
    issue_valid = 0; b_valid = 0; rt = 5'd13;
    tick();
    total++; if (rt_busy !== 1'b1) begin bad++; $display("FAIL sb_set_wins got=%b exp=1", rt_busy); end
    b_valid = 1;
    tick();
    b_valid = 0; rs = 0; rt = 0;
    tick();
  endtask

  task automatic test_zero_cases();
    issue_valid = 1; issue_reg = 5'd0; rs = 5'd0;
    tick();
    issue_valid = 0;
    #1;
    total++; if (rs_busy !== 1'b0) begin bad++; $display("FAIL zero_issue_busy got=%b exp=0", rs_busy); end
    b_valid = 1; b_reg = 5'd0; b_data = 32'hFFFF;
    #1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL zero_b_ready got=%b exp=1", b_ready); end
    tick();
    total++; if (regWrite !== 1'b0) begin bad++; $display("FAIL zero_b_we got=%b exp=0", regWrite); end
    b_reg = 5'd14; b_data = 32'hABCD;
    tick();
    b_valid = 0;
    total++; if (regWrite !== 1'b1 || writeReg !== 5'd14 || writeData !== 32'hABCD) begin
      bad++; $display("FAIL nonpend_b_write got=%b/%0d/%h exp=1/14/abcd", regWrite, writeReg, writeData); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if (mStall) begin
        a_valid = 0;
      end else begin
        a_reg  = 5'($urandom_range(0, 31));
        a_data = $urandom;
        a_valid = ($urandom_range(0, 9) < 7) && !mPend[a_reg];
      end
      if (!b_valid && ($urandom_range(0, 2) == 0)) begin
        b_valid = 1;
        b_reg   = 5'($urandom_range(0, 31));
        b_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_reg   = 5'($urandom_range(0, 31));
      rs = 5'($urandom_range(0, 31));
      rt = 5'($urandom_range(0, 31));
      #1;
      total++; if (b_ready !== !(a_valid && a_reg != 5'd0)) begin
        bad++; $display("FAIL rnd_b_ready cyc=%0d got=%b exp=%b", c, b_ready, !(a_valid && a_reg != 5'd0)); end
      total++; if (rs_busy !== exp_busy(rs)) begin
        bad++; $display("FAIL rnd_rs_busy cyc=%0d rs=%0d got=%b exp=%b", c, rs, rs_busy, exp_busy(rs)); end
      total++; if (rt_busy !== exp_busy(rt)) begin
        bad++; $display("FAIL rnd_rt_busy cyc=%0d rt=%0d got=%b exp=%b", c, rt, rt_busy, exp_busy(rt)); end
      tick();
      if (mGrantB) b_valid = 0;
      total++; if (regWrite !== mWe) begin bad++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", c, regWrite, mWe); end
      if (mWe) begin
        total++; if (writeReg !== mReg || writeData !== mData) begin
          bad++; $display("FAIL rnd_write cyc=%0d got=%0d/%h exp=%0d/%h", c, writeReg, writeData, mReg, mData); end
      end
      total++; if (stall_pipe !== mStall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, stall_pipe, mStall); end
    end
    idle_inputs();
    tick(); tick();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_reset_mid_fsm();
    test_a_only();
    test_collision();
    test_starvation();
    test_scoreboard();
    test_zero_cases();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writers:
  - the in-order pipeline writeback (port A, cannot be back-pressured);
  - the long-latency unit writeback (port B: mult/div/load-miss, valid/ready handshake).
- Tracks B-destined registers in a pending scoreboard and reports read hazards for rs/rt.
- Forces a pipeline stall when B starves.
- Drives regWrite/writeReg/writeData of the register file through one output register stage.

Parameters:
- NREG, 32, number of architectural registers (index width 5).
- DATA_W, 32, register data width.
- MAX_WAIT, 4, cycles B may be refused before a forced stall; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  pipeline writeback request.
- a_reg  in  5  pipeline destination register.
- a_data  in  32  pipeline write data.
- b_valid  in  1  long-latency writeback request.
- b_ready  out  1  B accepted this cycle when b_valid&&b_ready.
- b_reg  in  5  B destination register.
- b_data  in  32  B write data.
- issue_valid  in  1  B operation issued; mark issue_reg pending.
- issue_reg  in  5  register the issued B operation will write.
- rs  in  5  decode read index 1.
- rt  in  5  decode read index 2.
- rs_busy  out  1  rs not yet readable.
- rt_busy  out  1  rt not yet readable.
- stall_pipe  out  1  pipeline must freeze; a_valid must be 0 while high.
- regWrite  out  1  register-file write enable (registered).
- writeReg  out  5  register-file write index (registered).
- writeData  out  32  register-file write data (registered).

Behaviour:
- Reset: one clock and reset for the whole block; reset is synchronous and active-high. All outputs, the scoreboard and the wait counter are synchronously cleared. b_ready is forced to 0 while reset is high. Reset mid-operation discards any in-flight grant and pending bits.
- a_eff = a_valid && a_reg!=0. Writes to register 0 never assert regWrite.
- Grant (combinational): b_ready = !a_eff && !reset. A wins whenever a_eff; otherwise B is granted if b_valid.
- Handshake with b_reg==0: accepted (b_ready=1), no regWrite.
- Output stage: on a grant, regWrite/writeReg/writeData load the winner's values at the next edge; otherwise regWrite=0. A write becomes visible in the register file at the edge after that, so total latency is 2 edges.
- FSM with states IDLE, WAIT, FORCE:
  - IDLE -> WAIT when b_valid && !b_ready; wait_cnt=1.
  - WAIT: wait_cnt increments each refused cycle. It returns to IDLE on a B handshake. At wait_cnt==MAX_WAIT it moves to FORCE.
  - FORCE: stall_pipe=1 (registered, asserted in the cycle after entry). B is granted, since a_valid is guaranteed 0. Return to IDLE after the B handshake; stall_pipe drops the next cycle.
  - b_valid dropping in WAIT (illegal by protocol) -> IDLE.
- Scoreboard pending[NREG]:
  - Set on issue_valid for issue_reg!=0.
  - Cleared on a B handshake for b_reg.
  - Simultaneous set and clear of the same register: set wins.
  - Re-issue to an already pending register: stays set; the first completion clears it.
  - B completion for a non-pending register: write proceeds, no error.
- Hazards: rs_busy = pending[rs] || (regWrite && writeReg==rs && rs!=0); rt_busy likewise. Register 0 is never busy.
- Protocol rule checked by the bench: a_eff to a register with pending=1 is illegal, because the hazard unit must stall first.

Decomposition:
- Package regfile_pkg:
  - NREG;
  - REG_ZERO=5'd0;
  - typedef reg_idx_t (5 bits);
  - typedef word_t (32 bits);
  - enum arb_state_e {IDLE, WAIT, FORCE}.
- Sub-module regfile_scoreboard:
  - pending vector with set/clear ports;
  - combinational rs/rt lookup including the in-flight bypass term.
- The top holds the grant logic, FSM, wait counter and output register.

Test Plan:
- Reset mid-FSM:
  - Stimulus: reset high while in FORCE with pending[3]=1.
  - Response: next cycle stall_pipe=0, regWrite=0, pending all 0, b_ready=0 during reset.
- A only:
  - Stimulus: a_valid=1, a_reg=8, a_data=32'hDEADBEEF.
  - Response: next cycle regWrite=1, writeReg=8, writeData=32'hDEADBEEF.
  - Stimulus: a_reg=0.
  - Response: regWrite stays 0.
- Collision:
  - Stimulus: a_valid (reg 9) and b_valid (reg 10, 32'h5) in the same cycle.
  - Response: b_ready=0; reg 9 written first. Next cycle, with a_valid=0, B handshakes and reg 10 gets 32'h5.
- Starvation (MAX_WAIT=4):
  - Stimulus: a_valid held to reg 11 with b_valid high.
  - Response: FSM reaches FORCE after 4 refusals; stall_pipe=1 the next cycle. Bench drops a_valid; B is granted; stall_pipe=0 one cycle after the handshake.
- Scoreboard:
  - issue_valid reg 12 -> rs=12 gives rs_busy=1.
  - B handshake on reg 12 -> rs_busy remains 1 for the in-flight cycle, then 0.
  - issue and B completion of reg 13 in the same cycle -> pending[13]=1.
- Zero/odd cases:
  - issue_reg=0 -> no pending bit set.
  - B to reg 0 -> handshake accepted, regWrite=0.
  - B to a non-pending reg 14 -> written normally.
